// File: rtl/comptest_pkg.sv
// Shared definitions for the comparator-test serial engines (ADC reader, DAC writer).
package comptest_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_QUIET = 3'd4
    } state_t;

    // sclk half-period in system clocks for a given divider exponent
    function automatic int half_period(input int div);
        return 1 << (div - 1);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Two-flop rising-edge detector: one-cycle pulse the clock after the input rises.
module rise_detect (
    input  logic clock,
    input  logic _reset,
    input  logic d,
    output logic pulse
);

    logic [1:0] rd_ff;

    always_ff @(posedge clock) begin
        if (!_reset) rd_ff <= 2'b00;
        else         rd_ff <= {rd_ff[0], d};
    end

    assign pulse = (rd_ff == 2'b01);

endmodule

// File: rtl/adc_reader.sv
// Serial ADC readback: frames _cs/sclk, shifts in MSB-first sdo, drops leading bits,
// presents the result with a one-cycle valid strobe.
module adc_reader
    import comptest_pkg::*;
#(
    parameter int NBITS = 12,
    parameter int LEAD  = 4,
    parameter int DIV   = 4,
    parameter int QUIET = 16
) (
    input  logic             clock,
    input  logic             _reset,
    input  logic             adc_read,
    input  logic             sdo,
    output logic             _cs,
    output logic             sclk,
    output logic [NBITS-1:0] data,
    output logic             data_valid,
    output logic             busy
);

    localparam int H     = half_period(DIV);
    localparam int FRAME = LEAD + NBITS;
    localparam int CMAX  = (H > QUIET) ? H : QUIET;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int BW    = $clog2(FRAME + 1);

    state_t           state, st_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             ph, ph_n;            // 0: sclk low half, 1: sclk high half
    logic [BW-1:0]    bitcnt, bit_n;
    logic [NBITS-1:0] shift, shift_n, data_n;
    logic             pend, pend_n, busy_n, dv_n;
    logic             req, half_end;

    rise_detect u_req (
        .clock  (clock),
        ._reset (_reset),
        .d      (adc_read),
        .pulse  (req)
    );

    assign half_end = (cnt == CW'(H - 1));

    always_comb begin
        st_n    = state;
        cnt_n   = cnt + 1'b1;
        ph_n    = ph;
        bit_n   = bitcnt;
        shift_n = shift;
        data_n  = data;
        dv_n    = 1'b0;
        busy_n  = busy;
        pend_n  = pend | (req & busy);
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (req || pend) begin
                    st_n   = ST_SETUP;
                    busy_n = 1'b1;
                    pend_n = 1'b0;
                end
            end
            ST_SETUP: begin
                if (half_end) begin
                    st_n  = ST_SHIFT;
                    cnt_n = '0;
                    ph_n  = 1'b0;
                    bit_n = '0;
                end
            end
            ST_SHIFT: begin
                if (half_end) begin
                    cnt_n = '0;
                    if (!ph) begin
                        // sclk rises on this edge; the ADC has held sdo since the fall
                        ph_n    = 1'b1;
                        shift_n = {shift[NBITS-2:0], sdo};
                    end else if (bitcnt == BW'(FRAME - 1)) begin
                        st_n = ST_DONE;
                    end else begin
                        ph_n  = 1'b0;
                        bit_n = bitcnt + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                st_n   = ST_QUIET;
                cnt_n  = '0;
                data_n = shift;
                dv_n   = 1'b1;
            end
            ST_QUIET: begin
                if (cnt == CW'(QUIET - 1)) begin
                    cnt_n = '0;
                    // a queued request chains straight into the next frame, keeping busy high
                    if (pend || req) begin
                        st_n   = ST_SETUP;
                        pend_n = 1'b0;
                    end else begin
                        st_n   = ST_IDLE;
                        busy_n = 1'b0;
                    end
                end
            end
            default: begin
                st_n  = ST_IDLE;
                cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!_reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            ph         <= 1'b0;
            bitcnt     <= '0;
            shift      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            pend       <= 1'b0;
            _cs        <= 1'b1;
            sclk       <= 1'b1;
        end else begin
            state      <= st_n;
            cnt        <= cnt_n;
            ph         <= ph_n;
            bitcnt     <= bit_n;
            shift      <= shift_n;
            data       <= data_n;
            data_valid <= dv_n;
            busy       <= busy_n;
            pend       <= pend_n;
            // pins registered from next state so they change cleanly with the state
            _cs        <= !(st_n == ST_SETUP || st_n == ST_SHIFT);
            sclk       <= !(st_n == ST_SHIFT && !ph_n);
        end
    end

endmodule

// File: tb/tb_adc_reader.sv
// Directed bench for adc_reader with a behavioural ADC driving sdo on sclk falls.
module tb_adc_reader;

    localparam int NB = 12, LD = 4, DV = 2, QT = 4;

    logic          clock = 1'b0, _reset = 1'b0, adc_read = 1'b0, sdo = 1'b0;
    logic          _cs, sclk, data_valid, busy;
    logic [NB-1:0] data;
    int            errors = 0, checks = 0;

    always #5 clock = ~clock;

    adc_reader #(.NBITS(NB), .LEAD(LD), .DIV(DV), .QUIET(QT)) dut (
        .clock      (clock),
        ._reset     (_reset),
        .adc_read   (adc_read),
        .sdo        (sdo),
        ._cs        (_cs),
        .sclk       (sclk),
        .data       (data),
        .data_valid (data_valid),
        .busy       (busy)
    );

    // ADC model: loads a word when _cs falls, shifts a bit out on each sclk fall
    logic [15:0] word_q[$];
    logic [15:0] cur = 16'h0;
    int          idx = 0;
    always @(negedge _cs or negedge sclk) begin
        if (_cs === 1'b0) begin
            if (sclk === 1'b1) begin
                cur = 16'h0;
                if (word_q.size() > 0) cur = word_q.pop_front();
                idx = 0;
            end else begin
                sdo <= (idx < 16) ? cur[15-idx] : 1'b0;
                idx++;
            end
        end
    end

    int   nrise = 0, ncs = 0, nvalid = 0, viol = 0, badw = 0, cyc = 0, last_e = -1;
    logic prev_cs = 1'b1, prev_sclk = 1'b1;
    always @(posedge sclk) if (_cs === 1'b0) nrise++;
    always @(negedge _cs) ncs++;
    always @(negedge clock) begin
        cyc++;
        if (data_valid === 1'b1) nvalid++;
        if (prev_cs === 1'b1 && _cs === 1'b1 && sclk !== prev_sclk) viol++;
        if (prev_cs === 1'b1 && _cs === 1'b0 && sclk !== 1'b1) viol++;
        if (_cs === 1'b0 && prev_cs === 1'b0 && sclk !== prev_sclk) begin
            if (last_e >= 0 && cyc - last_e != 2) badw++;
            last_e = cyc;
        end
        if (_cs !== 1'b0) last_e = -1;
        prev_cs   = _cs;
        prev_sclk = sclk;
    end

    // Queue a word, pulse adc_read, return posedges (first sampling edge = 1) to data_valid
    task automatic do_frame(input logic [15:0] w, output int n);
        repeat (8) @(negedge clock);
        word_q.push_back(w);
        adc_read = 1'b1;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clock); #1;
            if (i == 2) adc_read = 1'b0;
            if (data_valid === 1'b1) begin n = i; break; end
        end
        adc_read = 1'b0;
    endtask

    task automatic test_reset();
        _reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            adc_read = ~adc_read;
            checks++;
            if ({_cs, sclk, data, data_valid, busy} !== {1'b1, 1'b1, 12'h000, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold: got cs=%b sclk=%b data=%h dv=%b busy=%b want 1 1 000 0 0",
                         _cs, sclk, data, data_valid, busy);
            end
        end
        adc_read = 1'b0;
        @(negedge clock);
        _reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++;
            if ({_cs, sclk, data, data_valid, busy} !== {1'b1, 1'b1, 12'h000, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_release: got cs=%b sclk=%b data=%h dv=%b busy=%b want 1 1 000 0 0",
                         _cs, sclk, data, data_valid, busy);
            end
        end
    endtask

    task automatic test_single();
        int n, r0, b0;
        r0 = nrise; b0 = badw;
        do_frame(16'h0AC3, n);
        checks++;
        if (n !== 69) begin errors++; $display("FAIL single_latency: got %0d want 69", n); end
        checks++;
        if (data !== 12'hAC3) begin errors++; $display("FAIL single_data: got %h want ac3", data); end
        checks++;
        if (_cs !== 1'b1) begin errors++; $display("FAIL single_cs_done: got %b want 1", _cs); end
        @(posedge clock); #1;
        checks++;
        if ({data_valid, _cs} !== 2'b01) begin
            errors++; $display("FAIL single_pulse_width: got dv=%b cs=%b want dv=0 cs=1", data_valid, _cs);
        end
        repeat (2) @(posedge clock); #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_quiet: got %b want 1", busy); end
        @(posedge clock); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b want 0", busy); end
        checks++;
        if (nrise - r0 !== 16) begin errors++; $display("FAIL single_sclk_rises: got %0d want 16", nrise - r0); end
        checks++;
        if (badw - b0 !== 0) begin errors++; $display("FAIL single_half_width: got %0d bad halves want 0", badw - b0); end
    endtask

    task automatic test_held();
        int v0, c0;
        v0 = nvalid; c0 = ncs;
        repeat (8) @(negedge clock);
        word_q.push_back(16'h0555);
        adc_read = 1'b1;
        repeat (500) @(negedge clock);
        adc_read = 1'b0;
        repeat (50) @(negedge clock);
        checks++;
        if (nvalid - v0 !== 1) begin errors++; $display("FAIL held_valids: got %0d want 1", nvalid - v0); end
        checks++;
        if (ncs - c0 !== 1) begin errors++; $display("FAIL held_frames: got %0d want 1", ncs - c0); end
        checks++;
        if (data !== 12'h555) begin errors++; $display("FAIL held_data: got %h want 555", data); end
    endtask

    task automatic test_back_to_back();
        int v0, c0, gap, found;
        v0 = nvalid; c0 = ncs; gap = 0;
        word_q.push_back(16'h0123);
        word_q.push_back(16'h0456);
        @(negedge clock); adc_read = 1'b1;
        repeat (2) @(negedge clock); adc_read = 1'b0;
        repeat (20) @(negedge clock); adc_read = 1'b1;
        repeat (2) @(negedge clock); adc_read = 1'b0;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock); #1;
            if (busy !== 1'b1) gap++;
            if (data_valid === 1'b1) begin found = 1; break; end
        end
        checks++;
        if (found !== 1 || data !== 12'h123) begin
            errors++; $display("FAIL b2b_first: got found=%0d data=%h want 1 123", found, data);
        end
        @(negedge clock); adc_read = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            @(posedge clock); #1;
            if (k == 3) adc_read = 1'b0;
            checks++;
            if ({_cs, busy} !== {(k < 5), 1'b1}) begin
                errors++; $display("FAIL b2b_cs_restart_%0d: got cs=%b busy=%b want cs=%b busy=1",
                                   k, _cs, busy, (k < 5));
            end
        end
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock); #1;
            if (busy !== 1'b1) gap++;
            if (data_valid === 1'b1) begin found = 1; break; end
        end
        checks++;
        if (found !== 1 || data !== 12'h456) begin
            errors++; $display("FAIL b2b_second: got found=%0d data=%h want 1 456", found, data);
        end
        repeat (60) @(negedge clock);
        checks++;
        if (nvalid - v0 !== 2 || ncs - c0 !== 2) begin
            errors++; $display("FAIL b2b_frames: got valids=%0d frames=%0d want 2 2", nvalid - v0, ncs - c0);
        end
        checks++;
        if (gap !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_busy: got gaps=%0d end_busy=%b want 0 0", gap, busy);
        end
    endtask

    task automatic test_mid_reset();
        int n, v0;
        do_frame(16'h0123, n);
        checks++;
        if (data !== 12'h123) begin errors++; $display("FAIL midrst_prior: got %h want 123", data); end
        repeat (10) @(negedge clock);
        word_q.push_back(16'h0FFF);
        v0 = nvalid;
        adc_read = 1'b1;
        repeat (2) @(negedge clock); adc_read = 1'b0;
        repeat (30) @(negedge clock);
        checks++;
        if (_cs !== 1'b0) begin errors++; $display("FAIL midrst_in_frame: got cs=%b want 0", _cs); end
        _reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if ({_cs, data, data_valid, busy} !== {1'b1, 12'h000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL midrst_abort: got cs=%b data=%h dv=%b busy=%b want 1 000 0 0",
                               _cs, data, data_valid, busy);
        end
        @(negedge clock); _reset = 1'b1;
        repeat (100) @(negedge clock);
        checks++;
        if (nvalid - v0 !== 0 || data !== 12'h000 || _cs !== 1'b1) begin
            errors++; $display("FAIL midrst_after: got valids=%0d data=%h cs=%b want 0 000 1",
                               nvalid - v0, data, _cs);
        end
    endtask

    task automatic test_boundary();
        int n;
        do_frame(16'hF000, n);
        checks++;
        if (n !== 69 || data !== 12'h000) begin
            errors++; $display("FAIL bound_zero: got lat=%0d data=%h want 69 000", n, data);
        end
        do_frame(16'hFFFF, n);
        checks++;
        if (n !== 69 || data !== 12'hFFF) begin
            errors++; $display("FAIL bound_ones: got lat=%0d data=%h want 69 fff", n, data);
        end
        do_frame(16'hF000, n);
        checks++;
        if (n !== 69 || data !== 12'h000) begin
            errors++; $display("FAIL bound_zero_again: got lat=%0d data=%h want 69 000", n, data);
        end
        repeat (20) @(negedge clock);
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL pin_rules: got %0d violations want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_held();
        test_back_to_back();
        test_mid_reset();
        test_boundary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
